nabp_image_writeback: RTL and testbench

NABP_IMAGE_WRITEBACK -- requirements
Module: nabp_image_writeback

---
 rtl/nabp_image_writeback.sv | 170 +++++++++++++++++
 tb/tb_nabp_image_writeback.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_image_writeback.sv
// Image write-back stage: buffers {address, value} words from the image
// addresser in a small FIFO and streams them into the image SRAM, one pass
// at a time, with back-pressure to upstream via ir_enable.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for ir_kick; any word presented here is an error
// RUN   | accepting words from upstream and writing them to SRAM
// DRAIN | upstream finished; flushing the remaining FIFO contents
// DONE  | single cycle, wb_done asserted, then back to IDLE

`ifndef kImageAddressLength
`define kImageAddressLength 16
`endif
`ifndef kCacheDataLength
`define kCacheDataLength 32
`endif

module nabp_image_writeback #(
   parameter int kAddrWidth = `kImageAddressLength,
   parameter int kDataWidth = `kCacheDataLength,
   parameter int kFifoDepth = 8,
   parameter int kSlack     = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ir_kick,
   input  logic                  ir_done,
   input  logic                  ir_addr_valid,
   input  logic [kAddrWidth-1:0] ir_addr,
   input  logic [kDataWidth-1:0] ir_val,
   output logic                  ir_enable,
   output logic                  mem_wr_req,
   input  logic                  mem_wr_ack,
   output logic [kAddrWidth-1:0] mem_addr,
   output logic [kDataWidth-1:0] mem_data,
   output logic                  wb_done,
   output logic                  wb_error,
   output logic [kAddrWidth:0]   wb_count
);

   localparam int kPtrWidth = $clog2(kFifoDepth);
   localparam int kOccWidth = kPtrWidth + 1;

   localparam logic [kOccWidth-1:0]  kOccFull  = kOccWidth'(kFifoDepth);
   localparam logic [kOccWidth-1:0]  kOccLimit = kOccWidth'(kFifoDepth - kSlack);
   localparam logic [kOccWidth-1:0]  kOccOne   = kOccWidth'(1);
   localparam logic [kPtrWidth-1:0]  kPtrOne   = kPtrWidth'(1);
   localparam logic [kAddrWidth:0]   kCountOne = (kAddrWidth+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [kAddrWidth-1:0] fifo_addr [kFifoDepth];
   logic [kDataWidth-1:0] fifo_data [kFifoDepth];
   logic [kPtrWidth-1:0]  rd_ptr;
   logic [kPtrWidth-1:0]  wr_ptr;
   logic [kOccWidth-1:0]  occ;
   logic [kOccWidth-1:0]  occ_d;

   logic fifo_empty;
   logic fifo_full;
   logic kick;
   logic push;
   logic pop;
   logic drop;

   // FIFO strobes and next occupancy. A full FIFO still accepts a word when
   // the head leaves on the same edge, since occupancy does not grow.
   always_comb begin
      fifo_empty = (occ == '0);
      fifo_full  = (occ == kOccFull);
      kick       = (state_q == S_IDLE) && ir_kick;
      pop        = mem_wr_req && mem_wr_ack;
      push       = (state_q == S_RUN) && ir_addr_valid && (!fifo_full || pop);
      drop       = ir_addr_valid && !push;
      occ_d      = occ;
      if (kick) begin
         occ_d = '0;
      end else if (push && !pop) begin
         occ_d = occ + kOccOne;
      end else if (pop && !push) begin
         occ_d = occ - kOccOne;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stray kicks and dones in other states fall through.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (ir_kick)    state_d = S_RUN;
         S_RUN:   if (ir_done)    state_d = S_DRAIN;
         S_DRAIN: if (fifo_empty) state_d = S_DONE;
         S_DONE:                  state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state and FIFO head; address/data forced to zero
   // whenever no request is pending so reset and idle look clean.
   always_comb begin
      mem_wr_req = !fifo_empty && ((state_q == S_RUN) || (state_q == S_DRAIN));
      wb_done    = (state_q == S_DONE);
      mem_addr   = '0;
      mem_data   = '0;
      if (mem_wr_req) begin
         mem_addr = fifo_addr[rd_ptr];
         mem_data = fifo_data[rd_ptr];
      end
   end

   // Pointers, occupancy, pass counters and the registered back-pressure flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occ       <= '0;
         wb_count  <= '0;
         wb_error  <= 1'b0;
         ir_enable <= 1'b0;
      end else begin
         if (kick) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wb_count <= '0;
            wb_error <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + kPtrOne;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + kPtrOne;
               if (wb_count != '1) begin
                  wb_count <= wb_count + kCountOne;
               end
            end
            if (drop) begin
               wb_error <= 1'b1;
            end
         end
         occ       <= occ_d;
         ir_enable <= (state_d == S_RUN) && (occ_d < kOccLimit);
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= ir_addr;
         fifo_data[wr_ptr] <= ir_val;
      end
   end

endmodule

// File: tb/tb_nabp_image_writeback.sv
// Bench for nabp_image_writeback: a queue-based pass model checked every
// cycle, a table of directed passes, hand sequences and random passes.

module tb_nabp_image_writeback;

   localparam int AW      = 5;
   localparam int DW      = 12;
   localparam int DEPTH   = 8;
   localparam int SLACK   = 2;
   localparam int CNT_MAX = (1 << (AW + 1)) - 1;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic          clk;
   logic          reset_n;
   logic          ir_kick;
   logic          ir_done;
   logic          ir_addr_valid;
   logic [AW-1:0] ir_addr;
   logic [DW-1:0] ir_val;
   logic          ir_enable;
   logic          mem_wr_req;
   logic          mem_wr_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          wb_done;
   logic          wb_error;
   logic [AW:0]   wb_count;

   nabp_image_writeback #(
      .kAddrWidth(AW),
      .kDataWidth(DW),
      .kFifoDepth(DEPTH),
      .kSlack(SLACK)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .ir_kick(ir_kick),
      .ir_done(ir_done),
      .ir_addr_valid(ir_addr_valid),
      .ir_addr(ir_addr),
      .ir_val(ir_val),
      .ir_enable(ir_enable),
      .mem_wr_req(mem_wr_req),
      .mem_wr_ack(mem_wr_ack),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .wb_done(wb_done),
      .wb_error(wb_error),
      .wb_count(wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } word_t;

   typedef struct {
      int n_words;
      int ack_mode;   // 0 tied 1, 1 toggling, 2 held 0 while pushing
      bit done_last;
      int exp_count;
      bit exp_err;
      int exp_writes;
   } vec_t;

   // reference model: a pass phase, a queue of pending words, error and count
   word_t q[$];
   int    m_phase;
   bit    m_err;
   int    m_cnt;
   bit    m_en;

   int n_tests;
   int n_fail;
   int n_writes;
   int n_done_pulses;
   int cyc;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_phase = P_IDLE;
      m_err   = 1'b0;
      m_cnt   = 0;
      m_en    = 1'b0;
   endtask

   task automatic check_outputs();
      bit            req_e;
      logic [AW-1:0] a_e;
      logic [DW-1:0] d_e;
      req_e = (q.size() > 0) && (m_phase == P_RUN || m_phase == P_DRAIN);
      a_e   = '0;
      d_e   = '0;
      if (req_e) begin
         a_e = q[0].a;
         d_e = q[0].d;
      end
      check($sformatf("cyc%0d.ir_enable", cyc), 32'(ir_enable), 32'(m_en));
      check($sformatf("cyc%0d.mem_wr_req", cyc), 32'(mem_wr_req), 32'(req_e));
      check($sformatf("cyc%0d.mem_addr", cyc), 32'(mem_addr), 32'(a_e));
      check($sformatf("cyc%0d.mem_data", cyc), 32'(mem_data), 32'(d_e));
      check($sformatf("cyc%0d.wb_done", cyc), 32'(wb_done), 32'(m_phase == P_DONE));
      check($sformatf("cyc%0d.wb_error", cyc), 32'(wb_error), 32'(m_err));
      check($sformatf("cyc%0d.wb_count", cyc), 32'(wb_count), 32'(m_cnt));
      if (wb_done === 1'b1) n_done_pulses++;
   endtask

   // one clock: drive inputs, advance the model, check outputs after the edge
   task automatic tick(input bit kick, input bit done, input bit valid, input bit ack,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      int    sz;
      bit    pop;
      word_t w;
      ir_kick       = kick;
      ir_done       = done;
      ir_addr_valid = valid;
      ir_addr       = a;
      ir_val        = d;
      mem_wr_ack    = ack;
      if (mem_wr_req === 1'b1 && ack) n_writes++;

      sz  = q.size();
      pop = (sz > 0) && (m_phase == P_RUN || m_phase == P_DRAIN) && ack;
      if (m_phase == P_IDLE && kick) begin
         q.delete();
         m_cnt   = 0;
         m_err   = 1'b0;
         m_phase = P_RUN;
      end else begin
         if (pop) begin
            w = q.pop_front();
            if (m_cnt < CNT_MAX) m_cnt++;
         end
         if (valid) begin
            if (m_phase == P_RUN && (sz < DEPTH || pop)) begin
               w.a = a;
               w.d = d;
               q.push_back(w);
            end else begin
               m_err = 1'b1;
            end
         end
         case (m_phase)
            P_RUN:   if (done) m_phase = P_DRAIN;
            P_DRAIN: if (sz == 0) m_phase = P_DONE;
            P_DONE:  m_phase = P_IDLE;
            default: ;
         endcase
      end
      m_en = (m_phase == P_RUN) && (q.size() < DEPTH - SLACK);

      cyc++;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   function automatic bit ack_for(input int mode);
      case (mode)
         1:       return cyc[0];
         3:       return 1'($urandom_range(0, 1));
         default: return 1'b1;
      endcase
   endfunction

   function automatic bit push_ack(input int mode);
      return (mode == 2) ? 1'b0 : ack_for(mode);
   endfunction

   task automatic wait_done(input string name, input int mode);
      int budget;
      budget = 0;
      while (n_done_pulses == 0 && budget < 300) begin
         tick(0, 0, 0, ack_for(mode), '0, '0);
         budget++;
      end
      tick(0, 0, 0, ack_for(mode), '0, '0);
      tick(0, 0, 0, ack_for(mode), '0, '0);
      check({name, ".done_pulses"}, 32'(n_done_pulses), 32'd1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".ir_enable"}, 32'(ir_enable), 32'd0);
      check({name, ".mem_wr_req"}, 32'(mem_wr_req), 32'd0);
      check({name, ".mem_addr"}, 32'(mem_addr), 32'd0);
      check({name, ".mem_data"}, 32'(mem_data), 32'd0);
      check({name, ".wb_done"}, 32'(wb_done), 32'd0);
      check({name, ".wb_error"}, 32'(wb_error), 32'd0);
      check({name, ".wb_count"}, 32'(wb_count), 32'd0);
   endtask

   task automatic run_vec(input int idx);
      vec_t  v;
      string nm;
      v  = vecs[idx];
      nm = $sformatf("vec%0d", idx);
      n_writes      = 0;
      n_done_pulses = 0;
      tick(1, 0, 0, push_ack(v.ack_mode), '0, '0);
      for (int i = 0; i < v.n_words; i++) begin
         tick(0, v.done_last && (i == v.n_words - 1), 1, push_ack(v.ack_mode),
              AW'(i), DW'($urandom));
      end
      if (!v.done_last || v.n_words == 0) tick(0, 1, 0, ack_for(v.ack_mode), '0, '0);
      wait_done(nm, v.ack_mode);
      check({nm, ".wb_count"}, 32'(wb_count), 32'(v.exp_count));
      check({nm, ".wb_error"}, 32'(wb_error), 32'(v.exp_err));
      check({nm, ".writes"}, 32'(n_writes), 32'(v.exp_writes));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      vecs[0] = '{5, 0, 1'b0, 5, 1'b0, 5};    // basic in-order pass
      vecs[1] = '{9, 2, 1'b0, 8, 1'b1, 8};    // overflow drops the 9th word
      vecs[2] = '{6, 1, 1'b1, 6, 1'b0, 6};    // done with last word, ack toggling
      vecs[3] = '{70, 0, 1'b0, CNT_MAX, 1'b0, 70}; // wb_count saturation
      vecs[4] = '{0, 0, 1'b0, 0, 1'b0, 0};    // empty pass

      reset_n       = 1'b0;
      ir_kick       = 1'b0;
      ir_done       = 1'b0;
      ir_addr_valid = 1'b0;
      ir_addr       = '0;
      ir_val        = '0;
      mem_wr_ack    = 1'b0;
      model_reset();
      #2;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      check_outputs();
      // stray ack with no request, outputs must stay quiet
      repeat (3) tick(0, 0, 0, 1, '0, '0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // back-pressure: ir_enable falls at occupancy 6, address held while stalled
      n_done_pulses = 0;
      tick(1, 0, 0, 0, '0, '0);
      for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, AW'(10 + i), DW'(100 + i));
      check("bp.en_at5", 32'(ir_enable), 32'd1);
      tick(0, 0, 1, 0, AW'(15), DW'(105));
      check("bp.en_at6", 32'(ir_enable), 32'd0);
      check("bp.head_addr", 32'(mem_addr), 32'd10);
      repeat (3) tick(0, 0, 0, 0, '0, '0);
      check("bp.hold_addr", 32'(mem_addr), 32'd10);
      check("bp.hold_data", 32'(mem_data), 32'd100);
      tick(0, 0, 0, 1, '0, '0);
      check("bp.en_rerise", 32'(ir_enable), 32'd1);
      check("bp.next_addr", 32'(mem_addr), 32'd11);
      tick(0, 1, 0, 1, '0, '0);
      wait_done("bp", 0);
      check("bp.wb_count", 32'(wb_count), 32'd6);

      // reset mid-pass with three words buffered
      tick(1, 0, 0, 0, '0, '0);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, AW'(20 + i), DW'(7 * i + 1));
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      check_outputs();
      repeat (2) tick(0, 0, 0, 1, '0, '0);
      n_done_pulses = 0;
      tick(1, 0, 0, 1, '0, '0);
      tick(0, 0, 1, 1, AW'(3), DW'(33));
      tick(0, 0, 1, 1, AW'(4), DW'(44));
      tick(0, 1, 0, 1, '0, '0);
      wait_done("postreset", 0);
      check("postreset.wb_count", 32'(wb_count), 32'd2);

      // word in IDLE flags an error; a second kick mid-pass is ignored
      tick(0, 0, 1, 1, AW'(7), DW'(55));
      check("idleword.err", 32'(wb_error), 32'd1);
      n_done_pulses = 0;
      tick(1, 0, 0, 1, '0, '0);
      check("idleword.kick_clears", 32'(wb_error), 32'd0);
      tick(0, 0, 1, 1, AW'(1), DW'(11));
      tick(1, 0, 1, 1, AW'(2), DW'(22));
      tick(0, 0, 1, 1, AW'(3), DW'(33));
      tick(0, 1, 0, 1, '0, '0);
      wait_done("kick2", 0);
      check("kick2.wb_error", 32'(wb_error), 32'd0);
      check("kick2.wb_count", 32'(wb_count), 32'd3);

      // random passes against the model
      for (int p = 0; p < 25; p++) begin
         int len;
         if ($urandom_range(0, 9) == 0) tick(0, 0, 1, 1'($urandom), AW'($urandom), DW'($urandom));
         n_done_pulses = 0;
         tick(1, 0, 0, 1'($urandom), '0, '0);
         len = $urandom_range(1, 30);
         for (int i = 0; i < len; i++) begin
            bit v;
            v = ($urandom_range(0, 2) != 0) && ((p % 2 == 1) || ir_enable);
            tick($urandom_range(0, 19) == 0, i == len - 1, v, 1'($urandom),
                 AW'($urandom), DW'($urandom));
         end
         wait_done($sformatf("rnd%0d", p), 3);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
